demux_2_1_sched: RTL and testbench

//   Sequential 1-to-2 demultiplexer; the receiving end of the switch/button 2:1 mux path.
//   The shared mux output (din) is time-sliced by an internal phase selector that toggles every TOGGLE_CYCLES.

---
 rtl/demux_2_1_sched.sv | 97 +++++++++
 tb/tb_demux_2_1_sched.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/demux_2_1_sched.sv
// Receiving end of the time-sliced switch/button 2:1 mux path: a phase selector
// routes the shared din into out_a (phase 0) or out_b (phase 1), with post-toggle blanking.
module demux_2_1_sched #(
  parameter int WIDTH         = 2,
  parameter int TOGGLE_CYCLES = 200000000,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic             sel,
  output logic             phase_tick,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic             chg_a,
  output logic             chg_b
);

  localparam int CNT_W = $clog2(TOGGLE_CYCLES);
  localparam int SET_W = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TOGGLE_CYCLES - 1);
  localparam logic [SET_W-1:0] SET_INIT = SET_W'(SETTLE_CYCLES);

  logic [CNT_W-1:0] phase_cnt_q, phase_cnt_d;
  logic [SET_W-1:0] settle_cnt_q, settle_cnt_d;
  logic             sel_q, sel_d;
  logic             phase_tick_q, phase_tick_d;
  logic [WIDTH-1:0] out_a_q, out_a_d;
  logic [WIDTH-1:0] out_b_q, out_b_d;
  logic             chg_a_q, chg_a_d;
  logic             chg_b_q, chg_b_d;

  always_comb begin
    phase_cnt_d  = phase_cnt_q;
    settle_cnt_d = settle_cnt_q;
    sel_d        = sel_q;
    phase_tick_d = 1'b0;
    out_a_d      = out_a_q;
    out_b_d      = out_b_q;
    chg_a_d      = 1'b0;
    chg_b_d      = 1'b0;
    if (en) begin
      // Capture always uses the pre-toggle sel, so a coincident toggle lands in the old channel.
      if (settle_cnt_q == '0) begin
        if (!sel_q) begin
          out_a_d = din;
          chg_a_d = (din != out_a_q);
        end else begin
          out_b_d = din;
          chg_b_d = (din != out_b_q);
        end
      end
      if (phase_cnt_q == CNT_LAST) begin
        phase_cnt_d  = '0;
        sel_d        = ~sel_q;
        phase_tick_d = 1'b1;
        settle_cnt_d = SET_INIT;
      end else begin
        phase_cnt_d = phase_cnt_q + CNT_W'(1);
        if (settle_cnt_q != '0) begin
          settle_cnt_d = settle_cnt_q - SET_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_cnt_q  <= '0;
      settle_cnt_q <= SET_INIT;
      sel_q        <= 1'b0;
      phase_tick_q <= 1'b0;
      out_a_q      <= '0;
      out_b_q      <= '0;
      chg_a_q      <= 1'b0;
      chg_b_q      <= 1'b0;
    end else begin
      phase_cnt_q  <= phase_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      sel_q        <= sel_d;
      phase_tick_q <= phase_tick_d;
      out_a_q      <= out_a_d;
      out_b_q      <= out_b_d;
      chg_a_q      <= chg_a_d;
      chg_b_q      <= chg_b_d;
    end
  end

  assign sel        = sel_q;
  assign phase_tick = phase_tick_q;
  assign out_a      = out_a_q;
  assign out_b      = out_b_q;
  assign chg_a      = chg_a_q;
  assign chg_b      = chg_b_q;

endmodule

// File: tb/tb_demux_2_1_sched.sv
// Bench for demux_2_1_sched: a vector table, directed multi-cycle sequences and
// randomized traffic checked against a phase/position arithmetic model.
module tb_demux_2_1_sched;

  localparam int WIDTH = 2;
  localparam int T     = 8;
  localparam int S     = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic [WIDTH-1:0] din;
  logic             sel, phase_tick, chg_a, chg_b;
  logic [WIDTH-1:0] out_a, out_b;

  demux_2_1_sched #(.WIDTH(WIDTH), .TOGGLE_CYCLES(T), .SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .din(din), .sel(sel),
    .phase_tick(phase_tick), .out_a(out_a), .out_b(out_b),
    .chg_a(chg_a), .chg_b(chg_b)
  );

  always #5 clk = ~clk;

  // Packed observation: {sel, phase_tick, out_a, out_b, chg_a, chg_b}
  typedef struct {
    logic       en;
    logic [1:0] din;
    logic [7:0] exp;
  } vec_t;

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  // Reference model: n counts enabled edges since reset; phase and in-phase position follow from it.
  int         n;
  logic [1:0] m_a, m_b;
  logic       m_ca, m_cb, m_tick;

  function automatic logic [7:0] dut_vec();
    return {sel, phase_tick, out_a, out_b, chg_a, chg_b};
  endfunction

  function automatic logic [7:0] model_vec();
    logic s;
    s = (((n / T) % 2) == 1);
    return {s, m_tick, m_a, m_b, m_ca, m_cb};
  endfunction

  task automatic model_reset();
    n = 0; m_a = '0; m_b = '0; m_ca = 1'b0; m_cb = 1'b0; m_tick = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_step(input logic en_i, input logic [1:0] din_i);
    int p;
    m_tick = 1'b0; m_ca = 1'b0; m_cb = 1'b0;
    if (en_i) begin
      p = n % T;
      if (p >= S) begin
        if (((n / T) % 2) == 0) begin
          m_ca = (din_i != m_a); m_a = din_i;
        end else begin
          m_cb = (din_i != m_b); m_b = din_i;
        end
      end
      if (p == T - 1) m_tick = 1'b1;
      n++;
    end
  endtask

  task automatic check_vec(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b (sel,tick,a,b,ca,cb)", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drives one cycle, advances the model and compares the DUT against it.
  task automatic cycle(input string name, input logic en_i, input logic [1:0] din_i);
    en = en_i; din = din_i;
    @(posedge clk);
    model_step(en_i, din_i);
    exp_q.push_back(model_vec());
    #1;
    check_vec(name, dut_vec(), exp_q.pop_front());
  endtask

  task automatic do_reset();
    en = 1'b0; din = '0; rst_n = 1'b0;
    @(posedge clk); #1;
    check_vec("reset_state", dut_vec(), 8'h00);
    rst_n = 1'b1;
    model_reset();
  endtask

  vec_t vecs[14];
  int   tick_edge[$];
  int   cnt;
  int   edge_no;
  logic found;

  initial begin
    vecs[0]  = '{1'b1, 2'b01, 8'b0000_0000};
    vecs[1]  = '{1'b1, 2'b01, 8'b0000_0000};
    vecs[2]  = '{1'b1, 2'b01, 8'b0001_0010};
    vecs[3]  = '{1'b1, 2'b01, 8'b0001_0000};
    vecs[4]  = '{1'b1, 2'b01, 8'b0001_0000};
    vecs[5]  = '{1'b1, 2'b01, 8'b0001_0000};
    vecs[6]  = '{1'b1, 2'b01, 8'b0001_0000};
    vecs[7]  = '{1'b1, 2'b11, 8'b1111_0010};
    vecs[8]  = '{1'b1, 2'b11, 8'b1011_0000};
    vecs[9]  = '{1'b1, 2'b00, 8'b1011_0000};
    vecs[10] = '{1'b1, 2'b10, 8'b1011_1001};
    vecs[11] = '{1'b1, 2'b10, 8'b1011_1000};
    vecs[12] = '{1'b0, 2'b01, 8'b1011_1000};
    vecs[13] = '{1'b1, 2'b01, 8'b1011_0101};

    rst_n = 1'b1; en = 1'b0; din = '0;
    #2;
    do_reset();

    // Table: blanking, first capture, coincident toggle capture, din glitches while blanked, en=0.
    foreach (vecs[i]) begin
      en = vecs[i].en; din = vecs[i].din;
      @(posedge clk); #1;
      check_vec($sformatf("vec%0d", i), dut_vec(), vecs[i].exp);
    end

    // Async reset mid-phase 1 with out_a=01, out_b=10.
    do_reset();
    for (int i = 0; i < 8; i++) cycle("pre_rst_a", 1'b1, 2'b01);
    for (int i = 0; i < 4; i++) cycle("pre_rst_b", 1'b1, 2'b10);
    check_vec("pre_rst_state", dut_vec(), 8'b1001_1000);
    #2 rst_n = 1'b0;
    #1 check_vec("async_reset", dut_vec(), 8'h00);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    cycle("post_rst", 1'b1, 2'b11);

    // Phase ticks at edges 8, 16, 24.
    do_reset();
    tick_edge.delete();
    for (int e = 1; e <= 24; e++) begin
      cycle("tick_run", 1'b1, 2'($urandom_range(0, 3)));
      if (phase_tick) tick_edge.push_back(e);
    end
    check_int("tick_count", tick_edge.size(), 3);
    foreach (tick_edge[i]) check_int($sformatf("tick_edge%0d", i), tick_edge[i], 8 * (i + 1));

    // en=0 for 5 cycles at phase_cnt=3 delays the tick by 5.
    do_reset();
    for (int i = 0; i < 3; i++) cycle("pause_pre", 1'b1, 2'b01);
    for (int i = 0; i < 5; i++) cycle("pause_hold", 1'b0, 2'b10);
    found = 1'b0; edge_no = 8;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle("pause_post", 1'b1, 2'b01);
      edge_no++;
      if (phase_tick) found = 1'b1;
    end
    check_int("pause_tick_found", int'(found), 1);
    check_int("pause_tick_edge", edge_no, 13);

    // Steady din across three phase-0 periods: a single chg_a pulse.
    do_reset();
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      cycle("steady", 1'b1, 2'b10);
      if (chg_a) cnt++;
    end
    check_int("steady_chg_a", cnt, 1);

    // Randomized traffic against the model.
    for (int r = 0; r < 4; r++) begin
      do_reset();
      for (int i = 0; i < 100; i++)
        cycle("random", ($urandom_range(0, 9) != 0), 2'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
